// File: rtl/muldiv_if.sv
// Handshake and result bus between a requester and muldiv_unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dbz;

  modport master (output start, cancel, op, a, b,
                  input  busy, done, hi, lo, dbz);
  modport slave  (input  start, cancel, op, a, b,
                  output busy, done, hi, lo, dbz);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, sign fix-up on the way out.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle product instead of WIDTH iterations.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // cnt runs 0..WIDTH-1 over the iterations, then one extra CALC cycle at WIDTH
  // applies the sign fix-up and registers the outputs.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] m_q;          // multiplicand or divisor magnitude
  logic [WIDTH-1:0] p_hi, p_lo;   // product accumulator or {remainder, quotient}
  logic [WIDTH-1:0] a_q;
  logic             is_div, neg_res, neg_rem, div_zero;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             dbz_q;

  logic             accept, calc_go, finish;
  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, res_hi, res_lo;

  assign accept  = (state == IDLE) && bus.start && !bus.cancel;
  assign calc_go = (state == CALC) && !bus.cancel;
  assign finish  = calc_go && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (bus.cancel) state_nxt = IDLE;
               else if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand magnitudes at acceptance; op[0]=1 selects the unsigned variants.
  always_comb begin
    sgn   = ~bus.op[0];
    a_neg = sgn & bus.a[WIDTH-1];
    b_neg = sgn & bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
  end

  always_comb begin
    mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m_q} : '0);
    div_trial = {p_hi, p_lo[WIDTH-1]} - {1'b0, m_q};
    div_ok    = ~div_trial[WIDTH];
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod_fast;
  assign prod_fast = {{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, p_lo};
`endif

  // Sign fix-up. The most-negative / -1 case needs no special handling: its
  // magnitude quotient 2^(WIDTH-1) is representable and is not negated.
  always_comb begin
    prod     = {p_hi, p_lo};
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -p_lo : p_lo;
    rem_fix  = neg_rem ? -p_hi : p_hi;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      res_hi = div_zero ? a_q : rem_fix;
      res_lo = div_zero ? '1  : quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      m_q      <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
      a_q      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      a_q      <= bus.a;
      is_div   <= bus.op[1];
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= bus.op[1] && (bus.b == '0);
      m_q      <= bus.op[1] ? b_mag : a_mag;
      p_hi     <= '0;
      p_lo     <= bus.op[1] ? a_mag : b_mag;
      dbz_q    <= 1'b0;
    end else if (finish) begin
      hi_q  <= res_hi;
      lo_q  <= res_lo;
      dbz_q <= is_div & div_zero;
    end else if (calc_go) begin
      cnt <= cnt + CNT_W'(1);
`ifdef MULDIV_FAST_MUL_EN
      if (!is_div) begin
        {p_hi, p_lo} <= prod_fast;
        cnt          <= CNT_LAST;
      end else
`endif
      if (is_div) begin
        p_hi <= div_ok ? div_trial[WIDTH-1:0] : {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
        p_lo <= {p_lo[WIDTH-2:0], div_ok};
      end else begin
        p_hi <= mul_sum[WIDTH:1];
        p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
      end
    end else if (state == CALC) begin
      cnt <= '0;
    end
  end

  assign bus.busy = (state == CALC);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.dbz  = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: reference results queued at issue, checked at done.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } res_t;

  res_t exp_q[$];
  res_t last;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic res_t model(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    res_t r;
    longint sa, sb, q, rm;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    case (op)
      MULT:  begin p = sa * sb; {r.hi, r.lo} = p; end
      MULTU: begin p = {32'b0, a} * {32'b0, b}; {r.hi, r.lo} = p; end
      DIV: begin
        if (b == '0) begin r.hi = a; r.lo = '1; r.dbz = 1'b1; end
        else begin q = sa / sb; rm = sa % sb; r.lo = W'(q); r.hi = W'(rm); end
      end
      default: begin
        if (b == '0) begin r.hi = a; r.lo = '1; r.dbz = 1'b1; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
    endcase
    return r;
  endfunction

  function automatic int lat_exp(logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
    if (!op[1]) return 2;
`endif
    return W + 1;
  endfunction

  // Start is held across one rising edge; never raised while done is showing.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    if (bus.done) @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (1) begin
      @(posedge clk);
      #1 n++;
      if (bus.done || n >= 200) break;
    end
  endtask

  function automatic res_t pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.cancel = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.dbz, bus.hi, bus.lo} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h, want all 0",
               bus.busy, bus.done, bus.dbz, bus.hi, bus.lo);
    end
    rst = 1'b0;
    last = '0;
  endtask

  task automatic test_mult();
    int n; res_t e;
    issue(MULT, 32'hFFFFFFFD, 32'd5);
    wait_done(n); e = pop_exp(); last = e;
    n_cmp++;
    if (n !== lat_exp(MULT)) begin n_err++; $display("FAIL mult_latency: got %0d want %0d", n, lat_exp(MULT)); end
    n_cmp++;
    if ({bus.hi, bus.lo, bus.dbz} !== {32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0}) begin
      n_err++; $display("FAIL mult_neg3x5: got hi=%h lo=%h dbz=%b want FFFFFFFF FFFFFFF1 0", bus.hi, bus.lo, bus.dbz);
    end
    n_cmp++;
    if ({bus.hi, bus.lo, bus.dbz} !== e) begin
      n_err++; $display("FAIL mult_model: got %h want %h", {bus.hi, bus.lo, bus.dbz}, e);
    end
  endtask

  task automatic test_multu();
    int n; res_t e;
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n); e = pop_exp(); last = e;
    n_cmp++;
    if (n !== lat_exp(MULTU)) begin n_err++; $display("FAIL multu_latency: got %0d want %0d", n, lat_exp(MULTU)); end
    n_cmp++;
    if ({bus.hi, bus.lo} !== {32'hFFFFFFFE, 32'h00000001} || {bus.hi, bus.lo, bus.dbz} !== e) begin
      n_err++; $display("FAIL multu_max: got hi=%h lo=%h want FFFFFFFE 00000001", bus.hi, bus.lo);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.done, bus.hi, bus.lo} !== {1'b0, e.hi, e.lo}) begin
      n_err++; $display("FAIL multu_hold: got done=%b hi=%h lo=%h want 0 %h %h", bus.done, bus.hi, bus.lo, e.hi, e.lo);
    end
  endtask

  task automatic test_div();
    int n; res_t e;
    issue(DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(n); e = pop_exp();
    n_cmp++;
    if ({bus.hi, bus.lo, bus.dbz} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0} || {bus.hi, bus.lo, bus.dbz} !== e) begin
      n_err++; $display("FAIL div_neg7by2: got hi=%h lo=%h dbz=%b want FFFFFFFF FFFFFFFD 0", bus.hi, bus.lo, bus.dbz);
    end
    issue(DIVU, 32'd7, 32'd0);
    n_cmp++;
    if (bus.dbz !== 1'b0) begin n_err++; $display("FAIL dbz_clear_on_start: got %b want 0", bus.dbz); end
    wait_done(n); e = pop_exp(); last = e;
    n_cmp++;
    if (n !== lat_exp(DIVU)) begin n_err++; $display("FAIL dbz_latency: got %0d want %0d", n, lat_exp(DIVU)); end
    n_cmp++;
    if ({bus.hi, bus.lo, bus.dbz} !== {32'd7, 32'hFFFFFFFF, 1'b1} || {bus.hi, bus.lo, bus.dbz} !== e) begin
      n_err++; $display("FAIL divu_by_zero: got hi=%h lo=%h dbz=%b want 00000007 FFFFFFFF 1", bus.hi, bus.lo, bus.dbz);
    end
  endtask

  task automatic test_cancel();
    int n; res_t e;
    issue(DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    void'(exp_q.pop_back());
    n_cmp++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, last.hi, last.lo}) begin
      n_err++; $display("FAIL cancel_flush: got busy=%b done=%b hi=%h lo=%h want 0 0 %h %h",
                        bus.busy, bus.done, bus.hi, bus.lo, last.hi, last.lo);
    end
    issue(DIVU, 32'd100, 32'd7);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL cancel_restart: got busy=%b want 1", bus.busy); end
    wait_done(n); e = pop_exp(); last = e;
    n_cmp++;
    if (n !== lat_exp(DIVU) || {bus.hi, bus.lo, bus.dbz} !== {32'd2, 32'd14, 1'b0}) begin
      n_err++; $display("FAIL cancel_rerun: got lat=%0d hi=%h lo=%h want %0d 2 14", n, bus.hi, bus.lo, lat_exp(DIVU));
    end
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.cancel = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_cancel_wins: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_rst_mid();
    issue(MULT, 32'd12345, 32'hFFFFFFFA);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    void'(exp_q.pop_back());
    n_cmp++;
    if ({bus.busy, bus.done, bus.dbz, bus.hi, bus.lo} !== '0) begin
      n_err++; $display("FAIL rst_mid_calc: got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
                        bus.busy, bus.done, bus.dbz, bus.hi, bus.lo);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_over_start: got busy=%b want 0", bus.busy); end
    rst = 1'b0; bus.start = 1'b0;
    last = '0;
  endtask

  task automatic test_busy_start();
    int n; res_t e;
    issue(DIV, 32'hFFFFFF9C, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.op = MULTU; bus.a = 32'hDEADBEEF; bus.b = 32'h12345678; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(n); e = pop_exp(); last = e;
    n_cmp++;
    if (n !== lat_exp(DIV) - 5) begin n_err++; $display("FAIL busy_start_latency: got %0d want %0d", n, lat_exp(DIV) - 5); end
    n_cmp++;
    if ({bus.hi, bus.lo, bus.dbz} !== e) begin
      n_err++; $display("FAIL busy_start_ignored: got %h want %h", {bus.hi, bus.lo, bus.dbz}, e);
    end
  endtask

  task automatic test_back_to_back();
    int n; res_t e;
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n); e = pop_exp();
    n_cmp++;
    if ({bus.hi, bus.lo, bus.dbz} !== {32'h0, 32'h80000000, 1'b0} || {bus.hi, bus.lo, bus.dbz} !== e) begin
      n_err++; $display("FAIL div_min_by_m1: got hi=%h lo=%h dbz=%b want 0 80000000 0", bus.hi, bus.lo, bus.dbz);
    end
    issue(MULT, 32'h7FFFFFFF, 32'h80000000);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy=%b want 1", bus.busy); end
    wait_done(n); e = pop_exp(); last = e;
    n_cmp++;
    if (n !== lat_exp(MULT) || {bus.hi, bus.lo, bus.dbz} !== e) begin
      n_err++; $display("FAIL b2b_result: got lat=%0d %h want %0d %h", n, {bus.hi, bus.lo, bus.dbz}, lat_exp(MULT), e);
    end
  endtask

  task automatic test_random();
    int n; res_t e;
    logic [1:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(3));
      a  = $urandom;
      b  = (i == 3) ? '0 : ((i % 2 == 0) ? W'($urandom_range(255)) : $urandom);
      issue(op, a, b);
      wait_done(n); e = pop_exp(); last = e;
      n_cmp++;
      if (n !== lat_exp(op) || {bus.hi, bus.lo, bus.dbz} !== e) begin
        n_err++; $display("FAIL random_%0d op=%0d a=%h b=%h: got lat=%0d %h want %0d %h",
                          i, op, a, b, n, {bus.hi, bus.lo, bus.dbz}, lat_exp(op), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_cancel();
    test_rst_mid();
    test_busy_start();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
